// File: rtl/id_operand_stage.sv
// id_operand_stage
// Instruction-decode / operand-fetch stage of the 5-stage pipeline.
// Splits the IF/ID instruction into register indices for the regfile,
// resolves RAW hazards by forwarding or stalling, and registers the
// decoded operands and controls into the ID/EX pipeline register.
//
// Build option: ID_FWD_EN
//   defined     : EX, MEM and WB forwarding; only load-use pairs stall.
//   not defined : only the WB bypass is kept; any used source that matches
//                 a writing EX or MEM destination stalls the stage.

module id_operand_stage (
  input  logic        clk,
  input  logic        clrn,
  input  logic [31:0] d_inst,
  input  logic        d_valid,
  input  logic        flush,
  output logic [4:0]  rna,
  output logic [4:0]  rnb,
  input  logic [31:0] qa,
  input  logic [31:0] qb,
  input  logic [4:0]  ex_wn,
  input  logic [4:0]  mem_wn,
  input  logic [4:0]  wb_wn,
  input  logic        ex_wreg,
  input  logic        mem_wreg,
  input  logic        wb_we,
  input  logic        ex_m2reg,
  input  logic [31:0] ex_alu,
  input  logic [31:0] mem_data,
  input  logic [31:0] wb_d,
  output logic        stall,
  output logic [31:0] e_a,
  output logic [31:0] e_b,
  output logic [31:0] e_imm,
  output logic [4:0]  e_wn,
  output logic [5:0]  e_op,
  output logic        e_wreg,
  output logic        e_m2reg,
  output logic        e_wmem,
  output logic        e_valid
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;

  typedef enum logic [1:0] {
    EXT_SIGN  = 2'd0,
    EXT_ZERO  = 2'd1,
    EXT_UPPER = 2'd2
  } ext_e;

  // Instruction fields
  logic [5:0]  w_op;
  logic [4:0]  w_rs;
  logic [4:0]  w_rt;
  logic [4:0]  w_rd;
  logic [15:0] w_imm16;

  assign w_op    = d_inst[31:26];
  assign w_rs    = d_inst[25:21];
  assign w_rt    = d_inst[20:16];
  assign w_rd    = d_inst[15:11];
  assign w_imm16 = d_inst[15:0];

  assign rna = w_rs;
  assign rnb = w_rt;

  // Decoded controls
  logic w_hasDst;
  logic w_dstIsRd;
  logic w_useRs;
  logic w_useRt;
  logic w_m2reg;
  logic w_wmem;
  ext_e w_ext;

  // Opcode decode: destination choice, source usage, memory controls, extension
  always_comb begin
    w_hasDst  = 1'b0;
    w_dstIsRd = 1'b0;
    w_useRs   = 1'b0;
    w_useRt   = 1'b0;
    w_m2reg   = 1'b0;
    w_wmem    = 1'b0;
    w_ext     = EXT_SIGN;
    case (w_op)
      OP_RTYPE: begin
        w_hasDst  = 1'b1;
        w_dstIsRd = 1'b1;
        w_useRs   = 1'b1;
        w_useRt   = 1'b1;
      end
      OP_LW: begin
        w_hasDst = 1'b1;
        w_useRs  = 1'b1;
        w_m2reg  = 1'b1;
      end
      OP_SW: begin
        w_useRs = 1'b1;
        w_useRt = 1'b1;
        w_wmem  = 1'b1;
      end
      OP_ADDI: begin
        w_hasDst = 1'b1;
        w_useRs  = 1'b1;
      end
      OP_ANDI, OP_ORI: begin
        w_hasDst = 1'b1;
        w_useRs  = 1'b1;
        w_ext    = EXT_ZERO;
      end
      OP_LUI: begin
        w_hasDst = 1'b1;
        w_ext    = EXT_UPPER;
      end
      OP_BEQ, OP_BNE: begin
        w_useRs = 1'b1;
        w_useRt = 1'b1;
      end
      default: begin
        w_hasDst = 1'b0;
      end
    endcase
  end

  // Destination index; instructions without a destination carry index 0
  logic [4:0] w_wn;
  logic       w_wreg;

  assign w_wn   = !w_hasDst ? 5'd0 : (w_dstIsRd ? w_rd : w_rt);
  assign w_wreg = w_hasDst && (w_wn != 5'd0);

  // Immediate extension
  logic [31:0] w_imm;

  // Select zero-extend, sign-extend or upper-half placement of the immediate
  always_comb begin
    w_imm = {{16{w_imm16[15]}}, w_imm16};
    case (w_ext)
      EXT_ZERO:  w_imm = {16'h0000, w_imm16};
      EXT_UPPER: w_imm = {w_imm16, 16'h0000};
      default:   w_imm = {{16{w_imm16[15]}}, w_imm16};
    endcase
  end

  // True when a stage writing index wn (nonzero) targets idx
  function automatic logic writesIdx(input logic we, input logic [4:0] wn,
                                     input logic [4:0] idx);
    return we && (wn != 5'd0) && (wn == idx);
  endfunction

  logic w_memHitA;
  logic w_memHitB;
  logic w_wbHitA;
  logic w_wbHitB;
  logic w_hazard;

  assign w_memHitA = writesIdx(mem_wreg, mem_wn, w_rs);
  assign w_memHitB = writesIdx(mem_wreg, mem_wn, w_rt);
  assign w_wbHitA  = writesIdx(wb_we, wb_wn, w_rs);
  assign w_wbHitB  = writesIdx(wb_we, wb_wn, w_rt);

  logic [31:0] w_opA;
  logic [31:0] w_opB;

`ifdef ID_FWD_EN
  // EX can forward only ALU results; a load in EX has no data yet
  logic w_exFwdA;
  logic w_exFwdB;
  logic w_loadHitA;
  logic w_loadHitB;

  assign w_exFwdA   = writesIdx(ex_wreg && !ex_m2reg, ex_wn, w_rs);
  assign w_exFwdB   = writesIdx(ex_wreg && !ex_m2reg, ex_wn, w_rt);
  assign w_loadHitA = writesIdx(ex_wreg && ex_m2reg, ex_wn, w_rs);
  assign w_loadHitB = writesIdx(ex_wreg && ex_m2reg, ex_wn, w_rt);
  assign w_hazard   = (w_useRs && w_loadHitA) || (w_useRt && w_loadHitB);

  // Operand A: r0, then EX, MEM, WB forwarding, then regfile
  always_comb begin
    w_opA = qa;
    if (w_rs == 5'd0)  w_opA = 32'h0;
    else if (w_exFwdA)  w_opA = ex_alu;
    else if (w_memHitA) w_opA = mem_data;
    else if (w_wbHitA)  w_opA = wb_d;
  end

  // Operand B: r0, then EX, MEM, WB forwarding, then regfile
  always_comb begin
    w_opB = qb;
    if (w_rt == 5'd0)  w_opB = 32'h0;
    else if (w_exFwdB)  w_opB = ex_alu;
    else if (w_memHitB) w_opB = mem_data;
    else if (w_wbHitB)  w_opB = wb_d;
  end
`else
  // Without EX/MEM paths, any writer in EX or MEM must drain first
  logic w_exHitA;
  logic w_exHitB;
  logic w_unusedFwd;

  assign w_exHitA    = writesIdx(ex_wreg, ex_wn, w_rs);
  assign w_exHitB    = writesIdx(ex_wreg, ex_wn, w_rt);
  assign w_hazard    = (w_useRs && (w_exHitA || w_memHitA)) ||
                       (w_useRt && (w_exHitB || w_memHitB));
  assign w_unusedFwd = ^{ex_alu, mem_data, ex_m2reg};

  // Operand A: r0, then WB bypass, then regfile
  always_comb begin
    w_opA = qa;
    if (w_rs == 5'd0) w_opA = 32'h0;
    else if (w_wbHitA) w_opA = wb_d;
  end

  // Operand B: r0, then WB bypass, then regfile
  always_comb begin
    w_opB = qb;
    if (w_rt == 5'd0) w_opB = 32'h0;
    else if (w_wbHitB) w_opB = wb_d;
  end
`endif

  // A flushed or empty slot never stalls the front end
  logic w_stall;

  assign w_stall = w_hazard && d_valid && !flush;
  assign stall   = w_stall;

  // ID/EX pipeline register
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [31:0] r_imm;
  logic [4:0]  r_wn;
  logic [5:0]  r_op;
  logic        r_wreg;
  logic        r_m2reg;
  logic        r_wmem;
  logic        r_valid;

  // Load decoded values, or insert a bubble on flush, stall or empty slot
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_a     <= 32'h0;
      r_b     <= 32'h0;
      r_imm   <= 32'h0;
      r_wn    <= 5'd0;
      r_op    <= 6'd0;
      r_wreg  <= 1'b0;
      r_m2reg <= 1'b0;
      r_wmem  <= 1'b0;
      r_valid <= 1'b0;
    end else if (flush || w_stall || !d_valid) begin
      r_a     <= 32'h0;
      r_b     <= 32'h0;
      r_imm   <= 32'h0;
      r_wn    <= 5'd0;
      r_op    <= 6'd0;
      r_wreg  <= 1'b0;
      r_m2reg <= 1'b0;
      r_wmem  <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_a     <= w_opA;
      r_b     <= w_opB;
      r_imm   <= w_imm;
      r_wn    <= w_wn;
      r_op    <= w_op;
      r_wreg  <= w_wreg;
      r_m2reg <= w_m2reg;
      r_wmem  <= w_wmem;
      r_valid <= 1'b1;
    end
  end

  assign e_a     = r_a;
  assign e_b     = r_b;
  assign e_imm   = r_imm;
  assign e_wn    = r_wn;
  assign e_op    = r_op;
  assign e_wreg  = r_wreg;
  assign e_m2reg = r_m2reg;
  assign e_wmem  = r_wmem;
  assign e_valid = r_valid;

endmodule

// File: tb/tb_id_operand_stage.sv
// tb_id_operand_stage
// Scoreboard bench for id_operand_stage: the driver computes the expected
// ID/EX contents from an instruction-table model and queues them; a monitor
// pops one entry per rising edge and compares.

module tb_id_operand_stage;

  logic        clk = 1'b0;
  logic        clrn = 1'b1;
  logic [31:0] d_inst = 32'h0;
  logic        d_valid = 1'b0;
  logic        flush = 1'b0;
  logic [4:0]  rna;
  logic [4:0]  rnb;
  logic [31:0] qa = 32'h0;
  logic [31:0] qb = 32'h0;
  logic [4:0]  ex_wn = 5'd0;
  logic [4:0]  mem_wn = 5'd0;
  logic [4:0]  wb_wn = 5'd0;
  logic        ex_wreg = 1'b0;
  logic        mem_wreg = 1'b0;
  logic        wb_we = 1'b0;
  logic        ex_m2reg = 1'b0;
  logic [31:0] ex_alu = 32'h0;
  logic [31:0] mem_data = 32'h0;
  logic [31:0] wb_d = 32'h0;
  logic        stall;
  logic [31:0] e_a;
  logic [31:0] e_b;
  logic [31:0] e_imm;
  logic [4:0]  e_wn;
  logic [5:0]  e_op;
  logic        e_wreg;
  logic        e_m2reg;
  logic        e_wmem;
  logic        e_valid;

  id_operand_stage dut (
    .clk(clk), .clrn(clrn), .d_inst(d_inst), .d_valid(d_valid), .flush(flush),
    .rna(rna), .rnb(rnb), .qa(qa), .qb(qb),
    .ex_wn(ex_wn), .mem_wn(mem_wn), .wb_wn(wb_wn),
    .ex_wreg(ex_wreg), .mem_wreg(mem_wreg), .wb_we(wb_we), .ex_m2reg(ex_m2reg),
    .ex_alu(ex_alu), .mem_data(mem_data), .wb_d(wb_d),
    .stall(stall), .e_a(e_a), .e_b(e_b), .e_imm(e_imm), .e_wn(e_wn), .e_op(e_op),
    .e_wreg(e_wreg), .e_m2reg(e_m2reg), .e_wmem(e_wmem), .e_valid(e_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic [4:0]  wn;
    logic [5:0]  op;
    logic        wreg;
    logic        m2reg;
    logic        wmem;
    logic        valid;
  } exp_t;

  // Instruction table row: dstSel 0=none 1=rt 2=rd; ext 0=sign 1=zero 2=upper
  typedef struct {
    int dstSel;
    bit useRs;
    bit useRt;
    bit m2reg;
    bit wmem;
    int ext;
  } info_t;

  exp_t expQ[$];
  exp_t zeroExp = '{a: 32'h0, b: 32'h0, imm: 32'h0, wn: 5'd0, op: 6'd0,
                    wreg: 1'b0, m2reg: 1'b0, wmem: 1'b0, valid: 1'b0};
  int   checks = 0;
  int   errors = 0;
  bit   armed = 1'b0;

  // Instruction table keyed by opcode; unknown opcodes behave as NOP
  function automatic info_t opInfo(input logic [5:0] op);
    info_t i = '{dstSel: 0, useRs: 0, useRt: 0, m2reg: 0, wmem: 0, ext: 0};
    case (op)
      6'h00: begin i.dstSel = 2; i.useRs = 1; i.useRt = 1; end
      6'h23: begin i.dstSel = 1; i.useRs = 1; i.m2reg = 1; end
      6'h2B: begin i.useRs = 1; i.useRt = 1; i.wmem = 1; end
      6'h08: begin i.dstSel = 1; i.useRs = 1; end
      6'h0C: begin i.dstSel = 1; i.useRs = 1; i.ext = 1; end
      6'h0D: begin i.dstSel = 1; i.useRs = 1; i.ext = 1; end
      6'h0F: begin i.dstSel = 1; i.ext = 2; end
      6'h04: begin i.useRs = 1; i.useRt = 1; end
      6'h05: begin i.useRs = 1; i.useRt = 1; end
      default: i.dstSel = 0;
    endcase
    return i;
  endfunction

  // Value a source register should hold, newest producer first
  function automatic logic [31:0] operandModel(input logic [4:0] idx, input logic [31:0] q);
    if (idx == 5'd0) return 32'h0;
`ifdef ID_FWD_EN
    if (ex_wreg && !ex_m2reg && ex_wn == idx) return ex_alu;
    if (mem_wreg && mem_wn == idx) return mem_data;
`endif
    if (wb_we && wb_wn == idx) return wb_d;
    return q;
  endfunction

  // Stall when a used source waits on a producer whose data is not reachable
  function automatic bit stallModel();
    info_t i = opInfo(d_inst[31:26]);
    int producers[$];
    int rs = int'(d_inst[25:21]);
    int rt = int'(d_inst[20:16]);
`ifdef ID_FWD_EN
    if (ex_wreg && ex_m2reg) producers.push_back(int'(ex_wn));
`else
    if (ex_wreg) producers.push_back(int'(ex_wn));
    if (mem_wreg) producers.push_back(int'(mem_wn));
`endif
    if (!d_valid || flush) return 1'b0;
    foreach (producers[k]) begin
      if (producers[k] != 0 && ((i.useRs && producers[k] == rs) || (i.useRt && producers[k] == rt)))
        return 1'b1;
    end
    return 1'b0;
  endfunction

  // Expected ID/EX contents after the coming rising edge
  function automatic exp_t expectedModel();
    info_t i = opInfo(d_inst[31:26]);
    exp_t e = zeroExp;
    logic [15:0] imm = d_inst[15:0];
    if (!clrn || flush || stallModel() || !d_valid) return zeroExp;
    e.a = operandModel(d_inst[25:21], qa);
    e.b = operandModel(d_inst[20:16], qb);
    if (i.ext == 1)      e.imm = 32'(imm);
    else if (i.ext == 2) e.imm = {imm, 16'h0000};
    else                 e.imm = {{16{imm[15]}}, imm};
    if (i.dstSel == 2)      e.wn = d_inst[15:11];
    else if (i.dstSel == 1) e.wn = d_inst[20:16];
    else                    e.wn = 5'd0;
    e.wreg  = (i.dstSel != 0) && (e.wn != 5'd0);
    e.op    = d_inst[31:26];
    e.m2reg = i.m2reg;
    e.wmem  = i.wmem;
    e.valid = 1'b1;
    return e;
  endfunction

  task automatic checkField(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic checkOutput(input exp_t e, input string tag);
    checkField({tag, ".e_a"}, e_a, e.a);
    checkField({tag, ".e_b"}, e_b, e.b);
    checkField({tag, ".e_imm"}, e_imm, e.imm);
    checkField({tag, ".e_wn"}, 32'(e_wn), 32'(e.wn));
    checkField({tag, ".e_op"}, 32'(e_op), 32'(e.op));
    checkField({tag, ".e_wreg"}, 32'(e_wreg), 32'(e.wreg));
    checkField({tag, ".e_m2reg"}, 32'(e_m2reg), 32'(e.m2reg));
    checkField({tag, ".e_wmem"}, 32'(e_wmem), 32'(e.wmem));
    checkField({tag, ".e_valid"}, 32'(e_valid), 32'(e.valid));
  endtask

  // Inputs already set; check combinational outputs, queue the registered result
  task automatic applyStimulus(input string tag);
    #1;
    checkField({tag, ".stall"}, 32'(stall), 32'(stallModel()));
    checkField({tag, ".rna"}, 32'(rna), 32'(d_inst[25:21]));
    checkField({tag, ".rnb"}, 32'(rnb), 32'(d_inst[20:16]));
    if (!clrn) checkOutput(zeroExp, {tag, ".asyncClear"});
    expQ.push_back(expectedModel());
    @(negedge clk);
  endtask

  task automatic setIdle();
    clrn = 1'b1; d_inst = 32'h0; d_valid = 1'b0; flush = 1'b0;
    qa = 32'hDEAD; qb = 32'hBEEF;
    ex_wn = 5'd0; mem_wn = 5'd0; wb_wn = 5'd0;
    ex_wreg = 1'b0; mem_wreg = 1'b0; wb_we = 1'b0; ex_m2reg = 1'b0;
    ex_alu = 32'h0; mem_data = 32'h0; wb_d = 32'h0;
  endtask

  task automatic randomizeInputs();
    logic [5:0] ops[10] = '{6'h00, 6'h23, 6'h2B, 6'h08, 6'h0C, 6'h0D, 6'h0F, 6'h04, 6'h05, 6'h3F};
    logic [5:0] op = ops[$urandom_range(0, 9)];
    logic [4:0] rs = 5'($urandom_range(0, 7));
    logic [4:0] rt = 5'($urandom_range(0, 7));
    logic [4:0] rd = 5'($urandom_range(0, 7));
    logic [10:0] low = 11'($urandom);
    if (op == 6'h3F) op = 6'($urandom);
    d_inst   = {op, rs, rt, rd, low};
    d_valid  = ($urandom_range(0, 9) != 0);
    flush    = ($urandom_range(0, 9) == 0);
    clrn     = ($urandom_range(0, 39) != 0);
    qa = $urandom; qb = $urandom;
    ex_wn  = 5'($urandom_range(0, 7));
    mem_wn = 5'($urandom_range(0, 7));
    wb_wn  = 5'($urandom_range(0, 7));
    ex_wreg  = 1'($urandom);
    mem_wreg = 1'($urandom);
    wb_we    = 1'($urandom);
    ex_m2reg = ($urandom_range(0, 2) == 0);
    ex_alu = $urandom; mem_data = $urandom; wb_d = $urandom;
  endtask

  function automatic logic [31:0] rType(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    return {6'h00, rs, rt, rd, 5'd0, 6'h20};
  endfunction

  function automatic logic [31:0] iType(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  // Monitor: one scoreboard entry per rising edge once the driver is armed
  always @(posedge clk) begin
    #1;
    if (expQ.size() > 0) begin
      checkOutput(expQ.pop_front(), "idex");
    end else if (armed) begin
      errors++;
      $display("[TB] FAIL scoreboard underflow got empty expected entry at %0t", $time);
    end
  end

  initial begin
    setIdle();
    @(negedge clk);
    armed = 1'b1;

    // Reset with random inputs, then release with an empty slot
    for (int n = 0; n < 3; n++) begin
      randomizeInputs(); clrn = 1'b0;
      applyStimulus("reset");
    end
    for (int n = 0; n < 2; n++) begin
      setIdle(); qa = $urandom; qb = $urandom;
      applyStimulus("idleAfterReset");
    end

    // EX forward of an ALU result into rs
    setIdle(); d_valid = 1'b1; d_inst = rType(5'd3, 5'd1, 5'd2);
    ex_wreg = 1'b1; ex_wn = 5'd3; ex_alu = 32'h1234;
    applyStimulus("exForward");

    // Priority EX > MEM > WB on r5
    setIdle(); d_valid = 1'b1; d_inst = rType(5'd5, 5'd0, 5'd6);
    ex_wreg = 1'b1; ex_wn = 5'd5; ex_alu = 32'h1;
    mem_wreg = 1'b1; mem_wn = 5'd5; mem_data = 32'h2;
    wb_we = 1'b1; wb_wn = 5'd5; wb_d = 32'h3;
    applyStimulus("prioAll");
    ex_wreg = 1'b0;
    applyStimulus("prioMemWb");
    mem_wreg = 1'b0;
    applyStimulus("prioWb");

    // Load-use: lw r4 in EX, sw reading rt=r4, then load moves to MEM and WB
    setIdle(); d_valid = 1'b1; d_inst = iType(6'h2B, 5'd1, 5'd4, 16'h0010);
    ex_wreg = 1'b1; ex_m2reg = 1'b1; ex_wn = 5'd4;
    applyStimulus("loadUse");
    ex_wreg = 1'b0; ex_m2reg = 1'b0; mem_wreg = 1'b1; mem_wn = 5'd4; mem_data = 32'h55;
    applyStimulus("loadUseMem");
    mem_wreg = 1'b0; wb_we = 1'b1; wb_wn = 5'd4; wb_d = 32'h55;
    applyStimulus("loadUseWb");

    // Flush wins over load-use
    setIdle(); d_valid = 1'b1; d_inst = iType(6'h2B, 5'd1, 5'd4, 16'h0010);
    ex_wreg = 1'b1; ex_m2reg = 1'b1; ex_wn = 5'd4; flush = 1'b1;
    applyStimulus("flushOverStall");

    // Immediate extension
    setIdle(); d_valid = 1'b1; d_inst = iType(6'h0D, 5'd2, 5'd7, 16'h8000);
    applyStimulus("oriZext");
    d_inst = iType(6'h08, 5'd2, 5'd7, 16'h8000);
    applyStimulus("addiSext");
    d_inst = iType(6'h0F, 5'd0, 5'd7, 16'hABCD);
    applyStimulus("luiUpper");

    // r0 is never forwarded
    setIdle(); d_valid = 1'b1; d_inst = rType(5'd0, 5'd0, 5'd9);
    ex_wreg = 1'b1; ex_wn = 5'd0; ex_alu = 32'h7;
    applyStimulus("r0NoForward");

    // Same-cycle WB write and read of one index
    setIdle(); d_valid = 1'b1; d_inst = rType(5'd6, 5'd6, 5'd8);
    wb_we = 1'b1; wb_wn = 5'd6; wb_d = 32'hCAFE_F00D;
    applyStimulus("wbBypass");

    // Valid instruction loaded, then reset dropped while load-use holds
    setIdle(); d_valid = 1'b1; d_inst = rType(5'd1, 5'd2, 5'd3);
    applyStimulus("preResetLoad");
    d_inst = iType(6'h2B, 5'd4, 5'd1, 16'h0);
    ex_wreg = 1'b1; ex_m2reg = 1'b1; ex_wn = 5'd4; clrn = 1'b0;
    applyStimulus("resetMidStall");
    clrn = 1'b1;
    applyStimulus("stallAfterReset");

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      randomizeInputs();
      applyStimulus("random");
    end

    setIdle();
    applyStimulus("drain");
    checkField("queueEmpty", 32'(expQ.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_operand_stage.md
# id_operand_stage

Instruction-decode/operand-fetch stage of the 5-stage pipeline, sitting directly upstream of the register file and feeding the EX stage. It:

- splits the IF/ID instruction into register indices and drives the regfile read ports;
- resolves RAW hazards by forwarding from EX, MEM and WB, or by stalling on load-use;
- registers decoded operands and controls into the ID/EX pipeline register, with stall, bubble and flush handling.

## Interface
Parameters:
- none (widths fixed: 32-bit datapath, 5-bit register index)

Ports:
- clk  in  1  pipeline clock, rising edge
- clrn  in  1  asynchronous active-low reset
- d_inst  in  32  instruction from IF/ID
- d_valid  in  1  IF/ID slot holds a real instruction
- flush  in  1  EX-resolved branch taken; kill the instruction in ID
- rna  out  5  regfile read index A = d_inst[25:21] (rs)
- rnb  out  5  regfile read index B = d_inst[20:16] (rt)
- qa, qb  in  32 each  regfile read data
- ex_wn, mem_wn, wb_wn  in  5 each  destination index of EX/MEM/WB instruction
- ex_wreg, mem_wreg, wb_we  in  1 each  that stage will write its destination
- ex_m2reg  in  1  EX instruction is a load
- ex_alu, mem_data, wb_d  in  32 each  result available at EX/MEM/WB
- stall  out  1  hold PC and IF/ID this cycle (combinational)
- e_a, e_b, e_imm  out  32 each  ID/EX operands and extended immediate
- e_wn  out  5  ID/EX destination index
- e_op  out  6  ID/EX opcode (funct passed via e_imm[5:0])
- e_wreg, e_m2reg, e_wmem, e_valid  out  1 each  ID/EX controls

## Operation
Decode uses op = d_inst[31:26].

| op | Instruction | Destination | Uses rs | Uses rt | Other |
|---|---|---|---|---|---|
| 000000 | R-type | rd, d_inst[15:11] | yes | yes | |
| 100011 | lw | rt | yes | no | m2reg=1 |
| 101011 | sw | none | yes | yes | wmem=1 |
| 001000 | addi | rt | yes | no | |
| 001100 | andi | rt | yes | no | |
| 001101 | ori | rt | yes | no | |
| 001111 | lui | rt | no | no | |
| 000100 | beq | none | yes | yes | |
| 000101 | bne | none | yes | yes | |

- Any other op decodes as a NOP: wreg=0, wmem=0, uses neither rs nor rt.
- Destination index 0 forces wreg=0.
- Immediate extension:
  - andi, ori: zero-extend.
  - lui: imm<<16.
  - all others: sign-extend.

Operand select, evaluated independently for A (rs) and B (rt), highest priority first:
1. EX match (ex_wreg, ex_wn≠0, ex_wn==idx, !ex_m2reg) → ex_alu
2. MEM match → mem_data
3. WB match → wb_d
4. otherwise qa/qb
- Index 0 always yields 0; r0 is never forwarded.

Load-use hazard:
- Condition: ex_wreg & ex_m2reg & ex_wn≠0, and ex_wn equals a *used* rs or rt, and d_valid & !flush.
- Effect: stall=1, and the ID/EX register loads a bubble.

ID/EX register update on each rising clk, highest priority first:
1. clrn=0 → all e_* = 0.
2. flush → bubble.
3. stall → bubble.
4. d_valid=0 → bubble.
5. otherwise load the decoded values, with e_valid=1.

- A bubble is e_valid=0, e_wreg=0, e_wmem=0, e_m2reg=0. Data fields are don't-care; the implementation drives them to 0.

## Timing
- Reset: every e_* output is 0. stall follows its combinational condition, and is 0 when d_valid=0.
- Latency: an instruction presented in cycle n appears on e_* after edge n+1.
- A stall lasts exactly one cycle per load-use pair. The next cycle the load is in MEM, so the value comes from mem_data.
- flush and load-use in the same cycle: flush wins, and stall=0.
- Same-cycle regfile write/read of the same index: the WB bypass supplies wb_d. The regfile's old value is never used.
- Reset asserted mid-stall: e_* clear immediately (asynchronously). stall depends only on inputs.

## Configuration
The feature switch is the macro `ID_FWD_EN`.

- **Defined:** full EX/MEM forwarding and load-use-only stalls, as described above.
- **Not defined:** EX and MEM forwarding are removed; the WB bypass is kept.
  - stall=1 whenever a used rs/rt matches a writing EX or MEM destination (index ≠ 0).
  - Worst case is a 2-cycle stall per dependency.

## Test plan
- **Reset:** clrn=0 with random inputs → all e_* = 0. After release, with d_valid=0, e_valid stays 0.
- **EX forward:**
  - Setup: add r3 in EX with ex_alu=0x1234; R-type using rs=r3 in ID; qa=0xDEAD.
  - Required: after the edge, e_a=0x1234 and stall=0.
- **Priority:**
  - Setup: r5 matched in EX (0x1), MEM (0x2) and WB (0x3).
  - Required: e_a=0x1. With the EX match removed, e_a=0x2; with the MEM match also removed, e_a=0x3.
- **Load-use:**
  - Setup: lw r4 in EX; sw using rt=r4 in ID.
  - Required: stall=1 for one cycle and a bubble (e_valid=0). Next cycle, with mem_data=0x55, e_b=0x55.
- **Flush over stall:** load-use condition and flush=1 in the same cycle → stall=0 and a bubble.
- **r0 and extension:**
  - ori with imm 0x8000 → e_imm=0x00008000.
  - addi with imm 0x8000 → e_imm=0xFFFF8000.
  - EX writing r0 with ex_alu=0x7 and rs=0 → e_a=0.
